// File: rtl/invaders_input_pkg.sv
// Shared constants for the Invaders-family input stage:
// scan codes, button bit positions, joystick bits and coin FSM states.
package invaders_input_pkg;

    localparam logic [7:0] SC_P1_UP     = 8'h75;
    localparam logic [7:0] SC_P1_DOWN   = 8'h72;
    localparam logic [7:0] SC_P1_LEFT   = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT  = 8'h74;
    localparam logic [7:0] SC_P1_FIREA  = 8'h14;
    localparam logic [7:0] SC_P1_FIREB  = 8'h11;
    localparam logic [7:0] SC_P1_FIREC  = 8'h29;
    localparam logic [7:0] SC_P1_FIRED  = 8'h12;

    localparam logic [7:0] SC_P2_UP     = 8'h2D;
    localparam logic [7:0] SC_P2_DOWN   = 8'h2B;
    localparam logic [7:0] SC_P2_LEFT   = 8'h23;
    localparam logic [7:0] SC_P2_RIGHT  = 8'h34;
    localparam logic [7:0] SC_P2_FIREA  = 8'h1C;
    localparam logic [7:0] SC_P2_FIREB  = 8'h1B;
    localparam logic [7:0] SC_P2_FIREC  = 8'h15;
    localparam logic [7:0] SC_P2_FIRED  = 8'h1D;

    localparam logic [7:0] SC_START1_A  = 8'h05;
    localparam logic [7:0] SC_START1_B  = 8'h16;
    localparam logic [7:0] SC_START2_A  = 8'h06;
    localparam logic [7:0] SC_START2_B  = 8'h1E;
    localparam logic [7:0] SC_COIN1_A   = 8'h76;
    localparam logic [7:0] SC_COIN1_B   = 8'h2E;
    localparam logic [7:0] SC_COIN2     = 8'h36;

    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_FIREA = 4;
    localparam int BTN_FIREB = 5;
    localparam int BTN_FIREC = 6;
    localparam int BTN_FIRED = 7;

    localparam int JOY_START1 = 8;
    localparam int JOY_START2 = 9;
    localparam int JOY_COIN   = 10;

    typedef enum logic [1:0] {
        CS_IDLE   = 2'd0,
        CS_ACTIVE = 2'd1,
        CS_HOLD   = 2'd2
    } coin_st_t;

endpackage

// File: rtl/invaders_input_coin_pulse.sv
// Coin stretcher: one fixed-length pulse per coin press,
// measured in VSync rising edges.
module coin_pulse
    import invaders_input_pkg::*;
#(
    parameter int COIN_FRAMES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    input  logic coin_raw,
    output logic coin
);

    localparam logic [3:0] FRAMES = 4'(COIN_FRAMES);

    coin_st_t   st_q, st_d;
    logic [3:0] cnt_q, cnt_d;
    logic       vs_prev_q, coin_prev_q;
    logic       coin_q, coin_d;
    logic       vs_rise, coin_rise;

    always_comb begin
        vs_rise   = vsync & ~vs_prev_q;
        coin_rise = coin_raw & ~coin_prev_q;
        st_d      = st_q;
        cnt_d     = cnt_q;
        coin_d    = coin_q;
        unique case (st_q)
            CS_IDLE: begin
                // a vsync edge coinciding with the coin edge is dropped here
                if (coin_rise) begin
                    st_d   = CS_ACTIVE;
                    cnt_d  = '0;
                    coin_d = 1'b1;
                end
            end
            CS_ACTIVE: begin
                if (vs_rise) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == FRAMES) begin
                        st_d   = CS_HOLD;
                        coin_d = 1'b0;
                    end
                end
            end
            CS_HOLD: begin
                if (!coin_raw) st_d = CS_IDLE;
            end
            default: begin
                st_d   = CS_IDLE;
                coin_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= CS_IDLE;
            cnt_q       <= '0;
            vs_prev_q   <= 1'b1;
            coin_prev_q <= 1'b1;
            coin_q      <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            vs_prev_q   <= vsync;
            coin_prev_q <= coin_raw;
            coin_q      <= coin_d;
        end
    end

    assign coin = coin_q;

endmodule

// File: rtl/invaders_input.sv
// Invaders input front end: PS/2 key decode, joystick merge,
// coin stretching and ioctl capture of game-select and DIP bytes.
module invaders_input
    import invaders_input_pkg::*;
#(
    parameter int COIN_FRAMES = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy1,
    input  logic [15:0] joy2,
    input  logic        vsync,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [7:0]  p1_btn,
    output logic [7:0]  p2_btn,
    output logic        start1,
    output logic        start2,
    output logic        coin,
    output logic [7:0]  mod,
    output logic [23:0] dip_sw
);

    logic       tog_q, armed_q, evt, pr;
    logic [7:0] kp1_q, kp1_d, kp2_q, kp2_d;
    // {coin2, coin1, start2, start1}
    logic [3:0] ksys_q, ksys_d;
    logic [7:0] p1_q, p1_d, p2_q, p2_d;
    logic       s1_q, s1_d, s2_q, s2_d;
    logic       craw_q, craw_d;
    logic [7:0]  mod_q = '0;
    logic [7:0]  mod_d;
    logic [23:0] dip_q = '0;
    logic [23:0] dip_d;
    logic        unused_bits;

    assign unused_bits = ^{joy1[15:11], joy2[15:11], ps2_key[8]};

    always_comb begin
        evt    = armed_q && (ps2_key[10] != tog_q);
        pr     = ps2_key[9];
        kp1_d  = kp1_q;
        kp2_d  = kp2_q;
        ksys_d = ksys_q;
        if (evt) begin
            case (ps2_key[7:0])
                SC_P1_UP:    kp1_d[BTN_UP]    = pr;
                SC_P1_DOWN:  kp1_d[BTN_DOWN]  = pr;
                SC_P1_LEFT:  kp1_d[BTN_LEFT]  = pr;
                SC_P1_RIGHT: kp1_d[BTN_RIGHT] = pr;
                SC_P1_FIREA: kp1_d[BTN_FIREA] = pr;
                SC_P1_FIREB: kp1_d[BTN_FIREB] = pr;
                SC_P1_FIREC: kp1_d[BTN_FIREC] = pr;
                SC_P1_FIRED: kp1_d[BTN_FIRED] = pr;
                SC_P2_UP:    kp2_d[BTN_UP]    = pr;
                SC_P2_DOWN:  kp2_d[BTN_DOWN]  = pr;
                SC_P2_LEFT:  kp2_d[BTN_LEFT]  = pr;
                SC_P2_RIGHT: kp2_d[BTN_RIGHT] = pr;
                SC_P2_FIREA: kp2_d[BTN_FIREA] = pr;
                SC_P2_FIREB: kp2_d[BTN_FIREB] = pr;
                SC_P2_FIREC: kp2_d[BTN_FIREC] = pr;
                SC_P2_FIRED: kp2_d[BTN_FIRED] = pr;
                SC_START1_A, SC_START1_B: ksys_d[0] = pr;
                SC_START2_A, SC_START2_B: ksys_d[1] = pr;
                SC_COIN1_A, SC_COIN1_B:   ksys_d[2] = pr;
                SC_COIN2:                 ksys_d[3] = pr;
                default: ;
            endcase
        end
        p1_d   = kp1_q | joy1[7:0];
        p2_d   = kp2_q | joy2[7:0];
        s1_d   = ksys_q[0] | joy1[JOY_START1] | joy2[JOY_START1];
        s2_d   = ksys_q[1] | joy1[JOY_START2] | joy2[JOY_START2];
        craw_d = ksys_q[2] | ksys_q[3] | joy1[JOY_COIN] | joy2[JOY_COIN];
    end

    // craw_q resets high so a coin held across reset reads as no new edge
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tog_q   <= 1'b0;
            armed_q <= 1'b0;
            kp1_q   <= '0;
            kp2_q   <= '0;
            ksys_q  <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            craw_q  <= 1'b1;
        end else begin
            tog_q   <= ps2_key[10];
            armed_q <= 1'b1;
            kp1_q   <= kp1_d;
            kp2_q   <= kp2_d;
            ksys_q  <= ksys_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            craw_q  <= craw_d;
        end
    end

    always_comb begin
        mod_d = mod_q;
        dip_d = dip_q;
        if (ioctl_wr && ioctl_index == 8'd1) mod_d = ioctl_dout;
        if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr[24:3] == '0) begin
            case (ioctl_addr[2:0])
                3'd0:    dip_d[7:0]   = ioctl_dout;
                3'd1:    dip_d[15:8]  = ioctl_dout;
                3'd2:    dip_d[23:16] = ioctl_dout;
                default: ;
            endcase
        end
    end

    // downloads happen while reset is held, so capture ignores it
    always_ff @(posedge clk_sys) begin
        mod_q <= mod_d;
        dip_q <= dip_d;
    end

    coin_pulse #(
        .COIN_FRAMES(COIN_FRAMES)
    ) u_coin (
        .clk      (clk_sys),
        .rst      (reset),
        .vsync    (vsync),
        .coin_raw (craw_q),
        .coin     (coin)
    );

    assign p1_btn = p1_q;
    assign p2_btn = p2_q;
    assign start1 = s1_q;
    assign start2 = s2_q;
    assign mod    = mod_q;
    assign dip_sw = dip_q;

endmodule

// File: tb/tb_invaders_input.sv
// Self-checking bench for invaders_input: random key/joystick traffic
// against a code-table model, coin pulse measurement and ioctl capture.
module tb_invaders_input;

    localparam int CF = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] ps2_key = '0;
    logic [15:0] joy1 = '0, joy2 = '0;
    logic        vsync = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_index = '0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  p1_btn, p2_btn, mod;
    logic        start1, start2, coin;
    logic [23:0] dip_sw;

    int tests = 0;
    int fails = 0;

    always #50 clk = ~clk;

    invaders_input #(.COIN_FRAMES(CF)) dut (
        .clk_sys(clk), .reset(rst), .ps2_key(ps2_key),
        .joy1(joy1), .joy2(joy2), .vsync(vsync),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .p1_btn(p1_btn), .p2_btn(p2_btn), .start1(start1),
        .start2(start2), .coin(coin), .mod(mod), .dip_sw(dip_sw)
    );

    // key table model, indexed by button bit
    logic [7:0] p1_codes [8] = '{8'h74, 8'h6B, 8'h72, 8'h75, 8'h14, 8'h11, 8'h29, 8'h12};
    logic [7:0] p2_codes [8] = '{8'h34, 8'h23, 8'h2B, 8'h2D, 8'h1C, 8'h1B, 8'h15, 8'h1D};
    logic [7:0] s1_codes [2] = '{8'h05, 8'h16};
    logic [7:0] s2_codes [2] = '{8'h06, 8'h1E};
    logic [7:0] m_p1 = '0, m_p2 = '0;
    logic       m_s1 = 1'b0, m_s2 = 1'b0;

    function automatic void model_key(input logic [7:0] code, input logic pr);
        for (int i = 0; i < 8; i++) begin
            if (code == p1_codes[i]) m_p1[i] = pr;
            if (code == p2_codes[i]) m_p2[i] = pr;
        end
        for (int i = 0; i < 2; i++) begin
            if (code == s1_codes[i]) m_s1 = pr;
            if (code == s2_codes[i]) m_s2 = pr;
        end
    endfunction

    function automatic logic [7:0] pick_code();
        logic [7:0] c;
        int sel;
        sel = $urandom_range(0, 5);
        case (sel)
            0, 1: c = p1_codes[$urandom_range(0, 7)];
            2, 3: c = p2_codes[$urandom_range(0, 7)];
            4:    c = ($urandom_range(0, 1) != 0) ? s1_codes[$urandom_range(0, 1)]
                                                  : s2_codes[$urandom_range(0, 1)];
            default: begin
                c = 8'($urandom);
                if (c == 8'h76 || c == 8'h2E || c == 8'h36) c = 8'h00;
            end
        endcase
        return c;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        joy1 = '0;
        joy2 = '0;
        vsync = 1'b0;
        m_p1 = '0; m_p2 = '0; m_s1 = 1'b0; m_s2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // drives one key event just after a clock edge
    task automatic send_key(input logic [7:0] code, input logic pr);
        @(posedge clk);
        #1 ps2_key = {~ps2_key[10], pr, 1'b0, code};
        model_key(code, pr);
    endtask

    // coin monitor state, updated once per cycle by step()
    int   c_pulses, c_len, c_vs_tot, fall_vs;
    int   lens[$];
    logic s_vs, s_coin;

    task automatic mon_clear();
        c_pulses = 0; c_len = 0; c_vs_tot = 0; fall_vs = -1;
        lens.delete();
        s_vs = vsync; s_coin = coin;
    endtask

    task automatic step(input logic vs);
        @(posedge clk);
        #1 vsync = vs;
        @(negedge clk);
        if (coin && !s_coin) begin
            c_pulses++;
            c_len = 0;
        end
        if (vsync && !s_vs) begin
            c_vs_tot++;
            if (coin) c_len++;
        end
        if (!coin && s_coin) begin
            lens.push_back(c_len);
            fall_vs = c_vs_tot;
        end
        s_vs = vsync;
        s_coin = coin;
    endtask

    task automatic frame();
        repeat (3) step(1'b1);
        repeat ($urandom_range(4, 9)) step(1'b0);
    endtask

    task automatic test_reset();
        joy1 = 16'h03FF;
        joy2 = 16'h07FF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (p1_btn !== 8'h00 || p2_btn !== 8'h00) begin
            fails++;
            $display("FAIL reset_btn: got %h/%h expected 00/00", p1_btn, p2_btn);
        end
        tests++;
        if ({start1, start2, coin} !== 3'b000) begin
            fails++;
            $display("FAIL reset_sys: got %b expected 000", {start1, start2, coin});
        end
        tests++;
        if (mod !== 8'h00 || dip_sw !== 24'h0) begin
            fails++;
            $display("FAIL powerup_capture: got %h/%h expected 00/000000", mod, dip_sw);
        end
        do_reset();
    endtask

    task automatic test_key_press();
        do_reset();
        send_key(8'h29, 1'b1);
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (p1_btn[6] !== 1'b0) begin
            fails++;
            $display("FAIL key_latency: got %b expected 0", p1_btn[6]);
        end
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (p1_btn !== 8'h40) begin
            fails++;
            $display("FAIL key_press: got %h expected 40", p1_btn);
        end
        send_key(8'h29, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (p1_btn !== 8'h00) begin
            fails++;
            $display("FAIL key_release: got %h expected 00", p1_btn);
        end
    endtask

    task automatic test_stale();
        logic bad;
        rst = 1'b1;
        ps2_key = 11'h475;
        joy1 = '0;
        joy2 = '0;
        m_p1 = '0; m_p2 = '0; m_s1 = 1'b0; m_s2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (p1_btn !== 8'h00) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL stale_toggle: got %h expected 00", p1_btn);
        end
        @(posedge clk);
        #1 ps2_key = 11'h275;
        model_key(8'h75, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (p1_btn !== m_p1 || p1_btn !== 8'h08) begin
            fails++;
            $display("FAIL stale_then_event: got %h expected 08", p1_btn);
        end
    endtask

    task automatic test_random_keys();
        logic [7:0] e1, e2;
        logic       es1, es2;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            send_key(pick_code(), 1'($urandom_range(0, 1)));
            joy1 = {6'b0, 10'($urandom)};
            joy2 = {6'b0, 10'($urandom)};
            repeat (2) @(posedge clk);
            @(negedge clk);
            e1  = m_p1 | joy1[7:0];
            e2  = m_p2 | joy2[7:0];
            es1 = m_s1 | joy1[8] | joy2[8];
            es2 = m_s2 | joy1[9] | joy2[9];
            tests++;
            if (p1_btn !== e1 || p2_btn !== e2) begin
                fails++;
                $display("FAIL rand_btn[%0d]: got %h/%h expected %h/%h", i, p1_btn, p2_btn, e1, e2);
            end
            tests++;
            if (start1 !== es1 || start2 !== es2) begin
                fails++;
                $display("FAIL rand_start[%0d]: got %b%b expected %b%b", i, start1, start2, es1, es2);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] code;
        do_reset();
        for (int r = 0; r < 6; r++) begin
            @(posedge clk);
            for (int i = 0; i < 5; i++) begin
                code = pick_code();
                #1 ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), 1'b0, code};
                model_key(code, ps2_key[9]);
                @(posedge clk);
            end
            @(posedge clk);
            @(negedge clk);
            tests++;
            if (p1_btn !== m_p1 || p2_btn !== m_p2 || start1 !== m_s1 || start2 !== m_s2) begin
                fails++;
                $display("FAIL back_to_back[%0d]: got %h %h %b%b expected %h %h %b%b",
                         r, p1_btn, p2_btn, start1, start2, m_p1, m_p2, m_s1, m_s2);
            end
        end
    endtask

    task automatic test_joy_latency();
        logic [7:0] old1, new1;
        do_reset();
        old1 = p1_btn;
        @(posedge clk);
        #1;
        joy1 = {6'b0, 10'($urandom)};
        joy1[7:0] = ~old1;
        new1 = joy1[7:0];
        @(negedge clk);
        tests++;
        if (p1_btn !== old1) begin
            fails++;
            $display("FAIL joy_early: got %h expected %h", p1_btn, old1);
        end
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (p1_btn !== new1 || start1 !== joy1[8]) begin
            fails++;
            $display("FAIL joy_latency: got %h/%b expected %h/%b", p1_btn, start1, new1, joy1[8]);
        end
        joy1 = '0;
    endtask

    task automatic test_coin_hold();
        do_reset();
        repeat (3) step(1'b0);
        mon_clear();
        joy2[10] = 1'b1;
        repeat (20) frame();
        tests++;
        if (c_pulses != 1 || lens.size() != 1) begin
            fails++;
            $display("FAIL coin_hold_count: got %0d pulses expected 1", c_pulses);
        end else begin
            tests++;
            if (lens[0] != CF) begin
                fails++;
                $display("FAIL coin_hold_len: got %0d expected %0d", lens[0], CF);
            end
        end
        joy2[10] = 1'b0;
        repeat (2) frame();
        joy2[10] = 1'b1;
        repeat (8) frame();
        tests++;
        if (c_pulses != 2 || lens.size() != 2 || coin !== 1'b0) begin
            fails++;
            $display("FAIL coin_repress: got %0d pulses coin=%b expected 2 coin=0", c_pulses, coin);
        end else begin
            tests++;
            if (lens[1] != CF) begin
                fails++;
                $display("FAIL coin_repress_len: got %0d expected %0d", lens[1], CF);
            end
        end
        joy2[10] = 1'b0;
    endtask

    task automatic test_short_coin();
        do_reset();
        repeat (3) step(1'b0);
        mon_clear();
        joy1[10] = 1'b1;
        repeat (3) step(1'b1);
        repeat (5) step(1'b0);
        joy1[10] = 1'b0;
        repeat (8) frame();
        tests++;
        if (c_pulses != 1 || lens.size() != 1) begin
            fails++;
            $display("FAIL short_coin_count: got %0d expected 1", c_pulses);
        end else begin
            tests++;
            if (lens[0] != CF || fall_vs != CF + 1) begin
                fails++;
                $display("FAIL short_coin_len: got %0d/%0d expected %0d/%0d",
                         lens[0], fall_vs, CF, CF + 1);
            end
        end
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(1, 6)) step(1'b0);
            mon_clear();
            joy1[10] = 1'b1;
            repeat ($urandom_range(1, 3)) frame();
            joy1[10] = 1'b0;
            repeat (8) frame();
            tests++;
            if (c_pulses != 1 || lens.size() != 1 || lens[0] != CF) begin
                fails++;
                $display("FAIL short_coin_rand[%0d]: got %0d pulses len %0d expected 1 len %0d",
                         i, c_pulses, (lens.size() > 0) ? lens[0] : -1, CF);
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        repeat (3) step(1'b0);
        joy1[10] = 1'b1;
        repeat (3) step(1'b0);
        tests++;
        if (coin !== 1'b1) begin
            fails++;
            $display("FAIL mid_pulse_pre: got %b expected 1", coin);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (coin !== 1'b0) begin
            fails++;
            $display("FAIL mid_pulse_async: got %b expected 0", coin);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_clear();
        repeat (6) frame();
        tests++;
        if (c_pulses != 0) begin
            fails++;
            $display("FAIL held_after_reset: got %0d pulses expected 0", c_pulses);
        end
        joy1[10] = 1'b0;
        repeat (2) frame();
        joy1[10] = 1'b1;
        repeat (6) frame();
        tests++;
        if (c_pulses != 1) begin
            fails++;
            $display("FAIL repress_after_reset: got %0d pulses expected 1", c_pulses);
        end
        joy1[10] = 1'b0;
    endtask

    task automatic ioctl_write(input logic [7:0] idx, input logic [24:0] addr,
                               input logic [7:0] data);
        @(posedge clk);
        #1;
        ioctl_wr = 1'b1;
        ioctl_index = idx;
        ioctl_addr = addr;
        ioctl_dout = data;
        @(posedge clk);
        #1 ioctl_wr = 1'b0;
    endtask

    task automatic test_download();
        logic [7:0] b0, b1, b2, m;
        rst = 1'b1;
        ioctl_write(8'd1, 25'($urandom), 8'h55);
        ioctl_write(8'd1, 25'($urandom), 8'h0A);
        ioctl_write(8'd254, 25'd0, 8'h11);
        ioctl_write(8'd254, 25'd1, 8'h22);
        ioctl_write(8'd254, 25'd2, 8'h33);
        ioctl_write(8'd254, 25'd8, 8'hFF);
        ioctl_write(8'd254, 25'd3, 8'hEE);
        ioctl_write(8'd7, 25'd0, 8'h99);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (mod !== 8'h0A || dip_sw !== 24'h332211) begin
            fails++;
            $display("FAIL download: got %h/%h expected 0A/332211", mod, dip_sw);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (mod !== 8'h0A || dip_sw !== 24'h332211) begin
            fails++;
            $display("FAIL capture_survives_reset: got %h/%h expected 0A/332211", mod, dip_sw);
        end
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); m = 8'($urandom);
        ioctl_write(8'd254, 25'd2, b2);
        ioctl_write(8'd1, 25'($urandom), m);
        ioctl_write(8'd254, 25'd0, b0);
        ioctl_write(8'd254, 25'h10, ~b0);
        ioctl_write(8'd254, 25'd1, b1);
        @(negedge clk);
        tests++;
        if (mod !== m || dip_sw !== {b2, b1, b0}) begin
            fails++;
            $display("FAIL download_rand: got %h/%h expected %h/%h", mod, dip_sw, m, {b2, b1, b0});
        end
    endtask

    initial begin
        test_reset();
        test_key_press();
        test_stale();
        test_random_keys();
        test_back_to_back();
        test_joy_latency();
        test_coin_hold();
        test_short_coin();
        test_reset_mid_pulse();
        test_download();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/invaders_input.md
# invaders_input

Front-end input stage for the Invaders-family cores, sitting between `hps_io` and the per-game input-port mux that builds GDB0..GDB2. It decodes `ps2_key` toggle events into held key states and merges them with both joysticks into P1, P2 and system button vectors. It stretches coin presses into a fixed-length, frame-counted pulse and captures the game-select byte and DIP bytes from the ioctl stream.

## Interface
- `COIN_FRAMES`, default 4: coin pulse length in VSync rising edges (1..15).
- `clk_sys`  in  1  system clock (10 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_key`  in  11  bit [10] is the event toggle, [9] is pressed, [8] is extended (ignored), [7:0] is the scan code.
- `joy1`, `joy2`  in  16 each  joystick words; [3:0] R/L/D/U, [7:4] fire A..D, [8] start1, [9] start2, [10] coin.
- `vsync`  in  1  video VSync, level, active-high.
- `ioctl_wr`  in  1  download write strobe.
- `ioctl_index`  in  8  download index.
- `ioctl_addr`  in  25  download address.
- `ioctl_dout`  in  8  download data.
- `p1_btn`, `p2_btn`  out  8 each  {fireD, fireC, fireB, fireA, up, down, left, right}.
- `start1`, `start2`  out  1 each  merged start buttons.
- `coin`  out  1  stretched coin pulse.
- `mod`  out  8  game-select byte.
- `dip_sw`  out  24  {sw2, sw1, sw0}.

## Operation
- **Event detect.** A key event occurs when `ps2_key[10]` differs from `tog_q`. `tog_q` loads `ps2_key[10]` every cycle. The `armed` flag clears on reset and sets on the first clock after reset. No event is decoded while `armed`=0, so a stale toggle level present at reset release does not produce an event.
- **Key table.** On an event, the matching key register is set to `pressed`; unmatched codes have no effect.
  - P1: 75 up, 72 down, 6B left, 74 right, 14 fireA, 11 fireB, 29 fireC, 12 fireD.
  - P2: 2D up, 2B down, 23 left, 34 right, 1C fireA, 1B fireB, 15 fireC, 1D fireD.
  - System: 05/16 start1, 06/1E start2, 76/2E coin1, 36 coin2.
- **Merge.**
  - `p1_btn` = kbd P1 | `joy1[7:0]`.
  - `p2_btn` = kbd P2 | `joy2[7:0]`.
  - `startN` = kbd startN | `joy1[7+N]` | `joy2[7+N]`.
  - `coin_raw` = coin1 | coin2 | `joy1[10]` | `joy2[10]`.
- **Coin FSM** (IDLE, ACTIVE, HOLD):
  - IDLE: a rising edge of `coin_raw` (against `coin_prev`) moves to ACTIVE with `cnt`=0 and `coin`=1.
  - ACTIVE: `cnt` increments on each `vsync` rising edge. When `cnt` reaches `COIN_FRAMES`, move to HOLD with `coin`=0.
  - HOLD: stay until `coin_raw`=0, then move to IDLE. Holding coin therefore yields exactly one pulse.
  - A `vsync` edge in the same cycle as IDLE→ACTIVE is not counted.
  - `coin_raw` dropping during ACTIVE does not shorten the pulse.
- **ioctl capture.**
  - `ioctl_wr` && index==1 writes `mod` from any address; the last byte wins.
  - `ioctl_wr` && index==254 && `addr[24:3]`==0 writes DIP byte `addr[2:0]`. Bytes 0..2 drive `dip_sw`; bytes 3..7 are written and discarded.
  - Capture registers are excluded from `reset` and initialise to 0 at power-up only. The system asserts `reset` for the whole download, so these registers must not be cleared by it.

## Timing
- **Reset values.** All key registers 0, `p1_btn`/`p2_btn`/`start1`/`start2`/`coin` 0, FSM IDLE, `cnt` 0, `tog_q` 0, `armed` 0, `vs_prev` 1, `coin_prev` 1.
- **Reset with coin held.** A coin held through reset release fires no pulse until it is released and pressed again.
- **Key latency.** A toggle change at edge k updates the key register at k+1 and the registered outputs at k+2.
- **Joystick latency.** Joystick bits reach outputs one clock after input.
- **Coin pulse.** `coin` rises two clocks after `coin_raw` rises, and falls one clock after the `COIN_FRAMES`-th counted vsync edge.
- **Reset mid-pulse.** Asynchronously forces `coin`=0 and the FSM to IDLE.
- **Consecutive events.** Toggle changes on consecutive cycles are each decoded; there is no event loss.

## Structure
- `invaders_input_pkg`:
  - scan-code localparams;
  - button bit-index constants (RIGHT=0 … FIRED=7);
  - coin FSM state enum `coin_st_t` (2 bits);
  - `JOY_START1`=8, `JOY_START2`=9, `JOY_COIN`=10.
- Sub-module `coin_pulse`: the FSM plus the 4-bit counter and the vsync/coin edge detectors, parameterised by `COIN_FRAMES`.
- The key decode, merge and ioctl capture stay in the top module.

## Test plan
- **Key press/release.** Reset, then toggle with code 29 pressed → `p1_btn[6]`=1 two clocks later. Next toggle with 29 released → 0.
- **Stale toggle.** Hold `ps2_key`=11'h475 (toggle=1, code 75, pressed=0) through reset release → no output change. Then toggle to 0 with pressed=1 and code 75 → `p1_btn[3]`=1.
- **Coin hold.** With `COIN_FRAMES`=4, hold `joy2[10]` for 20 vsync frames → exactly one `coin` pulse spanning 4 vsync rises. Release and press again → a second pulse.
- **Short coin.** Drop `coin_raw` after 1 frame → `coin` still lasts 4 frames. A vsync rising in the same cycle as the coin edge is not counted.
- **Download under reset.** Hold `reset`=1 while writing index 1 data 8'h0A, then index 254 at addresses 0..2 with 11/22/33 and address 8 with FF → after reset deasserts, `mod`=0A and `dip_sw`=24'h332211. Reset pulsed again → values unchanged.
- **Reset mid-pulse.** Assert `reset` mid-pulse → `coin`=0 immediately (asynchronously). Coin held across release → no pulse.
